// File: rtl/calc_sequencer_if.sv
// Operand-entry / result bus between a keypad front end and calc_sequencer.
//   num, num_pressed   : decimal digit and its one-cycle strobe
//   opt, opt_pressed   : opcode and its one-cycle strobe
//   submit             : one-cycle "=" strobe
//   disp               : entry value or result register (W bits)
//   disp_is_result     : disp currently shows the result register
//   result_valid       : one-cycle pulse on a new result
//   busy               : operation in progress
//   zero, carry, neg   : flags of the last completed operation
// master drives the strobes, slave (the sequencer) drives the outputs.
interface calc_sequencer_if #(
  parameter int unsigned BYTES = 2
);
  localparam int unsigned W = 8 * BYTES;

  logic [3:0]   num;
  logic         num_pressed;
  logic [2:0]   opt;
  logic         opt_pressed;
  logic         submit;
  logic [W-1:0] disp;
  logic         disp_is_result;
  logic         result_valid;
  logic         busy;
  logic         zero;
  logic         carry;
  logic         neg;

  modport master (
    output num, num_pressed, opt, opt_pressed, submit,
    input  disp, disp_is_result, result_valid, busy, zero, carry, neg
  );

  modport slave (
    input  num, num_pressed, opt, opt_pressed, submit,
    output disp, disp_is_result, result_valid, busy, zero, carry, neg
  );
endinterface

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: accumulates decimal operands, latches an
// operator, and executes it one byte per cycle (LSB first) on a W-bit datapath.
// Ports: clk, reset (async, active-high), bus (calc_sequencer_if.slave).
// Optional macro CALC_SAT_EN: add overflow clamps to all-ones, sub underflow
// clamps to zero; carry still reports the raw overflow/borrow.
module calc_sequencer #(
  parameter int unsigned BYTES = 2
) (
  input  logic             clk,
  input  logic             reset,
  calc_sequencer_if.slave  bus
);
  localparam int unsigned W     = 8 * BYTES;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned EXT_W = W + 4;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES - 1);
  localparam logic [EXT_W-1:0] ENTRY_MAX = {4'b0000, {W{1'b1}}};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTRY_A = 3'd1;
  localparam logic [2:0] S_OP_WAIT = 3'd2;
  localparam logic [2:0] S_ENTRY_B = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_CMP = 3'd5;

  logic [2:0]       state, state_n;
  logic [W-1:0]     entry, entry_n;
  logic [W-1:0]     a_reg, a_n;
  logic [W-1:0]     b_reg, b_n;
  logic [2:0]       op_reg, op_n;
  logic [2:0]       chain_op, chain_op_n;
  logic             chain, chain_n;
  logic [W-1:0]     result, result_n;
  logic [IDX_W-1:0] byte_idx, byte_idx_n;
  logic             cy, cy_n;
  logic             zero_r, zero_n;
  logic             carry_r, carry_n;
  logic             neg_r, neg_n;
  logic [W-1:0]     disp_r, disp_n;
  logic             dir_r, dir_n;
  logic             busy_r, busy_n;
  logic             rv_r, rv_n;

  // Strobe arbitration: submit > operator > digit; lower ones are dropped.
  logic             sub_s, opt_s, num_s;
  logic [EXT_W-1:0] acc_ext;
  logic             acc_ok;

  always_comb begin
    sub_s   = bus.submit;
    opt_s   = bus.opt_pressed & ~bus.submit;
    num_s   = bus.num_pressed & ~bus.submit & ~bus.opt_pressed & (bus.num < 4'd10);
    acc_ext = EXT_W'(entry) * EXT_W'(10) + EXT_W'(bus.num);
    acc_ok  = (acc_ext <= ENTRY_MAX);
  end

  // Byte-serial ALU slice for the byte selected by byte_idx.
  logic [4:0]   sh;
  logic [7:0]   a_byte, b_byte, res_byte;
  logic [8:0]   sum9, diff9;
  logic         cy_out, last;
  logic [W-1:0] merged, final_val;

  always_comb begin
    sh     = {byte_idx, 3'b000};
    a_byte = 8'(a_reg >> sh);
    b_byte = 8'(b_reg >> sh);
    sum9   = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, cy};
    diff9  = {1'b0, a_byte} - {1'b0, b_byte} - {8'b0, cy};
    res_byte = b_byte;
    cy_out   = 1'b0;
    case (op_reg)
      OP_ADD:         begin res_byte = sum9[7:0];  cy_out = sum9[8];  end
      OP_SUB, OP_CMP: begin res_byte = diff9[7:0]; cy_out = diff9[8]; end
      OP_AND:         res_byte = a_byte & b_byte;
      OP_OR:          res_byte = a_byte | b_byte;
      OP_XOR:         res_byte = a_byte ^ b_byte;
      default:        res_byte = b_byte;
    endcase
    last   = (byte_idx == LAST_IDX);
    merged = (result & ~(W'(8'hFF) << sh)) | (W'(res_byte) << sh);
`ifdef CALC_SAT_EN
    // Clamp is folded into the final byte write so DONE already shows it.
    if (op_reg == OP_ADD && cy_out)      final_val = {W{1'b1}};
    else if (op_reg == OP_SUB && cy_out) final_val = '0;
    else                                 final_val = merged;
`else
    final_val = merged;
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_n    = state;
    entry_n    = entry;
    a_n        = a_reg;
    b_n        = b_reg;
    op_n       = op_reg;
    chain_op_n = chain_op;
    chain_n    = chain;
    result_n   = result;
    byte_idx_n = byte_idx;
    cy_n       = cy;
    zero_n     = zero_r;
    carry_n    = carry_r;
    neg_n      = neg_r;
    rv_n       = 1'b0;

    case (state)
      S_IDLE: begin
        if (opt_s) begin
          a_n     = result;
          op_n    = bus.opt;
          state_n = S_OP_WAIT;
        end else if (num_s) begin
          entry_n = W'(bus.num);
          state_n = S_ENTRY_A;
        end
      end
      S_ENTRY_A: begin
        if (sub_s) begin
          result_n = entry;
          rv_n     = 1'b1;
          zero_n   = (entry == '0);
          carry_n  = 1'b0;
          neg_n    = 1'b0;
          state_n  = S_IDLE;
        end else if (opt_s) begin
          a_n     = entry;
          op_n    = bus.opt;
          entry_n = '0;
          state_n = S_OP_WAIT;
        end else if (num_s && acc_ok) begin
          entry_n = W'(acc_ext);
        end
      end
      S_OP_WAIT: begin
        if (opt_s) begin
          op_n = bus.opt;
        end else if (num_s) begin
          entry_n = W'(bus.num);
          state_n = S_ENTRY_B;
        end
      end
      S_ENTRY_B: begin
        if (sub_s || opt_s) begin
          b_n        = entry;
          chain_n    = opt_s;
          chain_op_n = opt_s ? bus.opt : chain_op;
          byte_idx_n = '0;
          cy_n       = 1'b0;
          state_n    = S_EXEC;
        end else if (num_s && acc_ok) begin
          entry_n = W'(acc_ext);
        end
      end
      S_EXEC: begin
        cy_n       = cy_out;
        byte_idx_n = byte_idx + IDX_W'(1);
        if (op_reg != OP_CMP) result_n = last ? final_val : merged;
        if (last) begin
          if (op_reg == OP_CMP) begin
            zero_n  = (a_reg == b_reg);
            carry_n = cy_out;
            neg_n   = cy_out;
          end else begin
            zero_n  = (final_val == '0);
            carry_n = (op_reg == OP_ADD || op_reg == OP_SUB) ? cy_out : 1'b0;
            neg_n   = (op_reg == OP_SUB) ? final_val[W-1] : 1'b0;
          end
          rv_n    = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (chain) begin
          a_n     = result;
          op_n    = chain_op;
          entry_n = '0;
          state_n = S_OP_WAIT;
        end else begin
          state_n = S_IDLE;
        end
        chain_n = 1'b0;
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are registered from next-state values so they track the state.
    dir_n  = !(state_n == S_ENTRY_A || state_n == S_ENTRY_B);
    disp_n = dir_n ? result_n : entry_n;
    busy_n = (state_n == S_EXEC || state_n == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      entry    <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= '0;
      chain_op <= '0;
      chain    <= 1'b0;
      result   <= '0;
      byte_idx <= '0;
      cy       <= 1'b0;
      zero_r   <= 1'b0;
      carry_r  <= 1'b0;
      neg_r    <= 1'b0;
      disp_r   <= '0;
      dir_r    <= 1'b1;
      busy_r   <= 1'b0;
      rv_r     <= 1'b0;
    end else begin
      state    <= state_n;
      entry    <= entry_n;
      a_reg    <= a_n;
      b_reg    <= b_n;
      op_reg   <= op_n;
      chain_op <= chain_op_n;
      chain    <= chain_n;
      result   <= result_n;
      byte_idx <= byte_idx_n;
      cy       <= cy_n;
      zero_r   <= zero_n;
      carry_r  <= carry_n;
      neg_r    <= neg_n;
      disp_r   <= disp_n;
      dir_r    <= dir_n;
      busy_r   <= busy_n;
      rv_r     <= rv_n;
    end
  end

  assign bus.disp           = disp_r;
  assign bus.disp_is_result = dir_r;
  assign bus.result_valid   = rv_r;
  assign bus.busy           = busy_r;
  assign bus.zero           = zero_r;
  assign bus.carry          = carry_r;
  assign bus.neg            = neg_r;
endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer (BYTES=2): scenario tasks drive
// keypad strobes, push expected results to a scoreboard, and a negedge
// monitor pops and compares on every result_valid pulse.
module tb_calc_sequencer;
  localparam int unsigned BYTES = 2;
  localparam int unsigned W     = 8 * BYTES;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         n;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  logic [W-1:0] model_result = '0;

  calc_sequencer_if #(.BYTES(BYTES)) bus ();
  calc_sequencer #(.BYTES(BYTES)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference model computed at full width.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] prev);
    exp_t e;
    logic [W:0] wide;
    e = '0;
    case (op)
      3'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        e.r = wide[W-1:0]; e.c = wide[W];
`ifdef CALC_SAT_EN
        if (e.c) e.r = {W{1'b1}};
`endif
      end
      3'd1: begin
        e.r = a - b; e.c = (a < b);
`ifdef CALC_SAT_EN
        if (e.c) e.r = '0;
`endif
        e.n = e.r[W-1];
      end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: e.r = a ^ b;
      3'd5: begin e.r = prev; e.c = (a < b); e.n = (a < b); end
      default: e.r = b;
    endcase
    e.z = (op == 3'd5) ? (a == b) : (e.r == '0);
    return e;
  endfunction

  task automatic expect_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(op, a, b, model_result);
    sb.push_back(e);
    model_result = e.r;
  endtask

  task automatic expect_value(input logic [W-1:0] v);
    exp_t e;
    e = '{r: v, z: (v == '0), c: 1'b0, n: 1'b0};
    sb.push_back(e);
    model_result = v;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset && bus.result_valid) begin
      exp_t e;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_result_valid: disp=%0d with no result expected", bus.disp);
      end else begin
        e = sb.pop_front();
        if ({bus.disp, bus.zero, bus.carry, bus.neg} !== {e.r, e.z, e.c, e.n}) begin
          miscompares++;
          $display("FAIL result: got disp=%0d z=%b c=%b n=%b, expected disp=%0d z=%b c=%b n=%b",
                   bus.disp, bus.zero, bus.carry, bus.neg, e.r, e.z, e.c, e.n);
        end
      end
    end
  end

  task automatic press(input logic s, input logic o_p, input logic n_p,
                       input logic [2:0] o, input logic [3:0] d);
    @(negedge clk);
    bus.submit = s; bus.opt_pressed = o_p; bus.num_pressed = n_p;
    bus.opt = o; bus.num = d;
    @(negedge clk);
    bus.submit = 1'b0; bus.opt_pressed = 1'b0; bus.num_pressed = 1'b0;
  endtask

  task automatic press_digit(input int d); press(1'b0, 1'b0, 1'b1, 3'd0, 4'(d)); endtask
  task automatic press_op(input int o);    press(1'b0, 1'b1, 1'b0, 3'(o), 4'd0); endtask
  task automatic press_submit();           press(1'b1, 1'b0, 1'b0, 3'd0, 4'd0); endtask

  task automatic press_num(input int v);
    int digs[$];
    int t;
    t = v;
    do begin digs.push_front(t % 10); t = t / 10; end while (t > 0);
    foreach (digs[i]) press_digit(digs[i]);
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (!bus.busy && sb.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: busy=%b pending=%0d, expected idle with none pending",
               name, bus.busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.disp, bus.result_valid, bus.busy, bus.zero, bus.carry, bus.neg, bus.disp_is_result}
        !== {{W{1'b0}}, 6'b000001}) begin
      miscompares++;
      $display("FAIL reset_outputs: disp=%0d rv=%b busy=%b z=%b c=%b n=%b dir=%b, expected 0s with dir=1",
               bus.disp, bus.result_valid, bus.busy, bus.zero, bus.carry, bus.neg, bus.disp_is_result);
    end
    reset = 1'b0;
    model_result = '0;
  endtask

  task automatic test_add_latency();
    int lat;
    press_num(123);
    vectors++;
    if ({bus.disp, bus.disp_is_result} !== {W'(123), 1'b0}) begin
      miscompares++;
      $display("FAIL entry_a_disp: disp=%0d dir=%b, expected 123 dir=0", bus.disp, bus.disp_is_result);
    end
    press_op(0);
    vectors++;
    if (bus.disp_is_result !== 1'b1) begin
      miscompares++;
      $display("FAIL op_wait_dir: dir=%b, expected 1", bus.disp_is_result);
    end
    press_num(45);
    expect_op(3'd0, W'(123), W'(45));
    @(negedge clk); bus.submit = 1'b1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.submit = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1) begin
          miscompares++;
          $display("FAIL exec_busy: busy=%b, expected 1", bus.busy);
        end
      end
      lat++;
      if (bus.result_valid) break;
    end
    vectors++;
    if (lat != BYTES + 1) begin
      miscompares++;
      $display("FAIL add_latency: got %0d cycles, expected %0d", lat, BYTES + 1);
    end
    wait_done("add");
  endtask

  task automatic test_overflow();
    press_num(65535);
    press_digit(6);
    vectors++;
    if (bus.disp !== W'(65535)) begin
      miscompares++;
      $display("FAIL entry_overflow: disp=%0d, expected 65535", bus.disp);
    end
    expect_value(W'(65535));
    press_submit();
    wait_done("overflow");
  endtask

  task automatic test_sub_cmp();
    press_num(5); press_op(1); press_num(7);
    expect_op(3'd1, W'(5), W'(7));
    press_submit(); wait_done("sub");
    press_num(3); press_op(5); press_num(9);
    expect_op(3'd5, W'(3), W'(9));
    press_submit(); wait_done("cmp_lt");
    press_num(9); press_op(5); press_num(9);
    expect_op(3'd5, W'(9), W'(9));
    press_submit(); wait_done("cmp_eq");
  endtask

  task automatic test_chain();
    press_num(2); press_op(0); press_num(3);
    expect_op(3'd0, W'(2), W'(3));
    press_op(0);
    wait_done("chain1");
    press_num(4);
    expect_op(3'd0, W'(5), W'(4));
    press_submit(); wait_done("chain2");
    vectors++;
    if ({bus.disp, bus.disp_is_result, bus.busy} !== {W'(9), 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL chain_final: disp=%0d dir=%b busy=%b, expected 9 1 0",
               bus.disp, bus.disp_is_result, bus.busy);
    end
    // Operator from IDLE reuses the result as A.
    press_op(0); press_num(1);
    expect_op(3'd0, W'(9), W'(1));
    press_submit(); wait_done("idle_op");
  endtask

  task automatic test_priority();
    press(1'b1, 1'b0, 1'b1, 3'd0, 4'd7);
    vectors++;
    if (bus.disp_is_result !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_idle_submit: dir=%b, expected 1 (digit dropped)", bus.disp_is_result);
    end
    press_digit(8);
    press(1'b0, 1'b1, 1'b1, 3'd4, 4'd6);
    press(1'b1, 1'b0, 1'b1, 3'd0, 4'd3);
    vectors++;
    if (bus.disp_is_result !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_opwait: dir=%b, expected 1 (still waiting for B)", bus.disp_is_result);
    end
    press_digit(2);
    press_digit(12);
    vectors++;
    if (bus.disp !== W'(2)) begin
      miscompares++;
      $display("FAIL digit_ge10: disp=%0d, expected 2", bus.disp);
    end
    expect_op(3'd4, W'(8), W'(2));
    press_submit(); wait_done("xor");
  endtask

  task automatic test_busy_ignore();
    press_num(1); press_op(0); press_num(1);
    expect_op(3'd0, W'(1), W'(1));
    press_submit();
    press_digit(5);
    wait_done("busy");
    vectors++;
    if ({bus.disp, bus.disp_is_result} !== {W'(2), 1'b1}) begin
      miscompares++;
      $display("FAIL busy_ignore: disp=%0d dir=%b, expected 2 dir=1", bus.disp, bus.disp_is_result);
    end
  endtask

  task automatic test_reset_mid_exec();
    press_num(100); press_op(0); press_num(200);
    @(negedge clk); bus.submit = 1'b1;
    @(negedge clk); bus.submit = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    #1;
    vectors++;
    if ({bus.disp, bus.result_valid, bus.busy, bus.zero, bus.carry, bus.neg, bus.disp_is_result}
        !== {{W{1'b0}}, 6'b000001}) begin
      miscompares++;
      $display("FAIL reset_mid_exec: disp=%0d rv=%b busy=%b z=%b c=%b n=%b dir=%b, expected 0s dir=1",
               bus.disp, bus.result_valid, bus.busy, bus.zero, bus.carry, bus.neg, bus.disp_is_result);
    end
    @(negedge clk); reset = 1'b0;
    model_result = '0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.disp} !== {1'b0, {W{1'b0}}}) begin
      miscompares++;
      $display("FAIL post_reset_idle: busy=%b disp=%0d, expected 0 0", bus.busy, bus.disp);
    end
    press_num(1); press_op(0); press_num(1);
    expect_op(3'd0, W'(1), W'(1));
    press_submit(); wait_done("after_reset");
  endtask

  initial begin
    bus.num = '0; bus.num_pressed = 1'b0; bus.opt = '0;
    bus.opt_pressed = 1'b0; bus.submit = 1'b0;
    test_reset();
    test_add_latency();
    test_overflow();
    test_sub_cmp();
    test_chain();
    test_priority();
    test_busy_ignore();
    test_reset_mid_exec();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
